// File: rtl/fifo_read_drain.sv
`default_nettype none
// ============================================================================
// fifo_read_drain : drains BURST_LEN words per start pulse from a FIFO read
//   port into a 2-entry valid/ready output buffer. Optional +1 sequence checker
//   is built when the macro DRAIN_SEQ_CHECK_EN is defined.
// Revision: 1.0
// ============================================================================
module fifo_read_drain #(
  parameter int MEMORY_WIDTH = 4,
  parameter int BURST_LEN    = 5,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    r_clk,
  input  logic                    rrst,
  input  logic                    start,
  input  logic                    r_empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic [MEMORY_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    words_read,
  output logic                    seq_err
);

  localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_WIDTH-1:0]    issued_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    inflight_q;
  logic [1:0]              ocnt_q,  ocnt_d;
  logic [MEMORY_WIDTH-1:0] buf0_q,  buf0_d;
  logic [MEMORY_WIDTH-1:0] buf1_q,  buf1_d;
  logic [CNT_WIDTH-1:0]    words_read_q;
  logic                    push;
  logic                    pop;
  logic                    credit_ok;

  // A read is only issued if its word is guaranteed a buffer slot on arrival.
  assign credit_ok = ({1'b0, ocnt_q} + {2'b00, inflight_q}) < 3'd2;
  assign r_en      = (state_q == RUN) && !r_empty && (issued_q < BURST_CNT) && credit_ok;

  assign push       = inflight_q;
  assign out_valid  = (ocnt_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = buf0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_read = words_read_q;

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_q  <= IDLE;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            issued_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (r_en) begin
            issued_q <= issued_q + 1'b1;
          end
          if (issued_q == BURST_CNT) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight_q && (ocnt_q == 2'd0)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Head is always buf0; a simultaneous push and pop keeps the count and order.
  always_comb begin
    ocnt_d = ocnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (ocnt_q == 2'd0) begin
          buf0_d = rdata;
        end else begin
          buf1_d = rdata;
        end
        ocnt_d = ocnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        ocnt_d = ocnt_q - 2'd1;
      end
      2'b11: begin
        if (ocnt_q == 2'd1) begin
          buf0_d = rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata;
        end
      end
      default: begin
        ocnt_d = ocnt_q;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      inflight_q   <= 1'b0;
      ocnt_q       <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      words_read_q <= '0;
    end else begin
      inflight_q <= r_en;
      ocnt_q     <= ocnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      if (pop) begin
        words_read_q <= words_read_q + 1'b1;
      end
    end
  end

`ifdef DRAIN_SEQ_CHECK_EN
  logic                    seeded_q;
  logic [MEMORY_WIDTH-1:0] expect_q;
  logic                    seq_err_q;

  // After a mismatch the expectation follows the word actually seen.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      seeded_q  <= 1'b0;
      expect_q  <= '0;
      seq_err_q <= 1'b0;
    end else if (pop) begin
      seeded_q <= 1'b1;
      expect_q <= out_data + 1'b1;
      if (seeded_q && (out_data != expect_q)) begin
        seq_err_q <= 1'b1;
      end
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_drain.sv
`default_nettype none
// ============================================================================
// tb_fifo_read_drain : randomized scoreboard bench for fifo_read_drain with a
//   queue-based FIFO model. Honors DRAIN_SEQ_CHECK_EN for seq_err expectations.
// Revision: 1.0
// ============================================================================
module tb_fifo_read_drain;

  localparam int MW  = 4;
  localparam int BL  = 5;
  localparam int CW  = 8;
  localparam int TMO = 400;

  logic          clk = 1'b0;
  logic          rrst;
  logic          start;
  logic          r_empty = 1'b1;
  logic [MW-1:0] rdata = '0;
  logic          r_en;
  logic [MW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [CW-1:0] words_read;
  logic          seq_err;

  logic          force_empty;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  logic [MW-1:0] fifo_q[$];
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] next_val = 4'd1;

  int            nchecks = 0;
  int            nerrs   = 0;
  int            ren_cnt = 0;
  int            done_cnt = 0;
  int            pop_cnt = 0;

  logic [CW-1:0] mdl_words = '0;
  logic          mdl_seeded = 1'b0;
  logic [MW-1:0] mdl_last = '0;
  logic          mdl_err = 1'b0;

  always #5 clk = ~clk;

  fifo_read_drain #(.MEMORY_WIDTH(MW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .r_clk      (clk),
    .rrst       (rrst),
    .start      (start),
    .r_empty    (r_empty),
    .rdata      (rdata),
    .r_en       (r_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .words_read (words_read),
    .seq_err    (seq_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: read data appears one cycle after an accepted r_en.
  always @(posedge clk) begin
    if (r_en) begin
      if (fifo_q.size() == 0) begin
        chk("fifo_underflow_read", 32'd1, 32'd0);
      end else begin
        rdata <= fifo_q.pop_front();
      end
    end
    r_empty <= (fifo_q.size() == 0) || force_empty;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 2) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rrst) begin
      // Everything already read or about to be read is lost; what the FIFO still holds remains.
      exp_q = fifo_q;
      if (r_en && exp_q.size() > 0) void'(exp_q.pop_front());
      mdl_words  = '0;
      mdl_seeded = 1'b0;
      mdl_err    = 1'b0;
    end else begin
      chk("seq_err", 32'(seq_err), 32'(mdl_err));
      chk("words_read", 32'(words_read), 32'(mdl_words));
      if (r_en) begin
        ren_cnt++;
        if (r_empty) chk("r_en_while_empty", 32'd1, 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_buffer_empty", 32'(out_valid), 32'd0);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'(out_data), 32'hDEAD);
        end else begin
          logic [MW-1:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
`ifdef DRAIN_SEQ_CHECK_EN
          if (mdl_seeded && (e != (mdl_last + 4'd1))) mdl_err = 1'b1;
`endif
          mdl_seeded = 1'b1;
          mdl_last   = e;
          mdl_words  = mdl_words + 8'd1;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_val);
      exp_q.push_back(next_val);
      next_val = next_val + 4'd1;
    end
    cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < TMO) begin
      cycle();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    cycle();
    rrst = 1'b1;
    cycle();
    rrst = 1'b0;
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_words_read", 32'(words_read), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, p0, n;
    rrst = 1'b1;
    start = 1'b0;
    force_empty = 1'b0;
    repeat (3) cycle();
    do_reset();

    // Basic burst with downstream always ready.
    rdy_mode = 0;
    load(BL);
    r0 = ren_cnt; d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    repeat (3) cycle();
    chk("t1_ren_cycles", 32'(ren_cnt - r0), 32'(BL));
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_words_read", 32'(words_read), 32'd5);
    chk("t1_all_delivered", 32'(exp_q.size()), 32'd0);

    // Back-pressure: only two reads may be outstanding.
    rdy_mode = 2;
    load(BL);
    r0 = ren_cnt; d0 = done_cnt;
    pulse_start();
    repeat (20) cycle();
    chk("t2_ren_held", 32'(ren_cnt - r0), 32'd2);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_r_en_low", 32'(r_en), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    rdy_mode = 0;
    wait_done(d0);
    repeat (2) cycle();
    chk("t2_ren_total", 32'(ren_cnt - r0), 32'(BL));
    chk("t2_words_read", 32'(words_read), 32'd10);

    // Empty stall mid-burst.
    load(BL);
    r0 = ren_cnt; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (ren_cnt - r0 < 2 && n < 50) begin cycle(); n++; end
    force_empty = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_r_en", 32'(r_en), 32'd0);
      chk("t3_stall_busy", 32'(busy), 32'd1);
      cycle();
    end
    force_empty = 1'b0;
    wait_done(d0);
    repeat (2) cycle();
    chk("t3_ren_total", 32'(ren_cnt - r0), 32'(BL));
    chk("t3_words_read", 32'(words_read), 32'd15);

    // Start during RUN is ignored; then a second burst.
    load(BL);
    r0 = ren_cnt; d0 = done_cnt;
    pulse_start();
    cycle();
    pulse_start();
    wait_done(d0);
    repeat (10) cycle();
    chk("t4_ren_single", 32'(ren_cnt - r0), 32'(BL));
    chk("t4_done_single", 32'(done_cnt - d0), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    load(BL);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    repeat (2) cycle();
    chk("t4_words_read", 32'(words_read), 32'd25);

    // Randomized ready and empty stalls.
    for (int b = 0; b < 8; b++) begin
      rdy_mode = 1;
      load(BL + int'($urandom_range(0, 2)));
      r0 = ren_cnt; d0 = done_cnt;
      repeat ($urandom_range(0, 3)) cycle();
      pulse_start();
      n = 0;
      while (done_cnt == d0 && n < TMO) begin
        force_empty = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) start = 1'b1; else start = 1'b0;
        cycle();
        n++;
      end
      start = 1'b0;
      force_empty = 1'b0;
      if (done_cnt == d0) chk("rand_done_timeout", 32'd0, 32'd1);
      repeat (2) cycle();
      chk("rand_ren_total", 32'(ren_cnt - r0), 32'(BL));
    end
    rdy_mode = 0;
    repeat (3) cycle();

    // Abort with rrst after two pops.
    load(BL);
    p0 = pop_cnt;
    pulse_start();
    n = 0;
    while (pop_cnt - p0 < 2 && n < 50) begin cycle(); n++; end
    do_reset();
    r0 = ren_cnt;
    repeat (10) cycle();
    chk("t5_no_r_en", 32'(ren_cnt - r0), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Sequence break: jump by 5 inside the stream.
    load(2);
    next_val = next_val + 4'd4;
    load(3);
    load(BL);
    for (int b = 0; b < 2; b++) begin
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);
      repeat (2) cycle();
    end
`ifdef DRAIN_SEQ_CHECK_EN
    chk("t6_seq_err_sticky", 32'(seq_err), 32'd1);
`else
    chk("t6_seq_err_tied", 32'(seq_err), 32'd0);
`endif

    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
`default_nettype wire
